// File: rtl/dmem_pkg.sv
// Shared encodings for the handshaked data memory: access widths, FSM states,
// and the alignment/legality rule applied to a latched request.
package dmem_pkg;

  localparam logic [1:0] RW_BYTE = 2'b00;
  localparam logic [1:0] RW_HALF = 2'b01;
  localparam logic [1:0] RW_WORD = 2'b10;
  localparam logic [1:0] RW_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // True when the access width is illegal or the address is not naturally aligned.
  function automatic logic bad_access(input logic [1:0] rwtype, input logic [1:0] lane);
    case (rwtype)
      RW_HALF: return lane[0];
      RW_WORD: return lane != 2'b00;
      RW_ILL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane steering: formats a loaded word for byte/half/word loads and builds
// byte enables plus lane-replicated write data for stores.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  rwtype,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    rdata    = '0;
    be       = '0;
    wdata_sh = '0;
    case (rwtype)
      RW_BYTE: begin
        rdata    = {{24{sext & byte_sel[7]}}, byte_sel};
        be       = 4'b0001 << lane;
        wdata_sh = {4{wdata[7:0]}};
      end
      RW_HALF: begin
        rdata    = {{16{sext & half_sel[15]}}, half_sel};
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
      end
      RW_WORD: begin
        rdata    = word;
        be       = 4'b1111;
        wdata_sh = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// Handshaked data memory: accepts one load/store per valid/ready request,
// executes it after LATENCY cycles and holds the response until consumed.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0400_4000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_rwtype,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_sext,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT_LAST = 4'(LATENCY - 1);

  state_t      state_reg, state_next;
  logic [3:0]  lat_cnt_reg;
  logic        wen_reg, sext_reg;
  logic [1:0]  rwtype_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  logic             accept, access_done, commit, req_err;
  logic [32:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word, load_fmt, wdata_sh;
  logic [3:0]       be;

  assign req_ready   = (state_reg == IDLE) || ((state_reg == RESP) && resp_ready);
  assign accept      = req_valid && req_ready;
  assign access_done = (state_reg == ACCESS) && (lat_cnt_reg == LAT_LAST);

  // Addresses below the base wrap to a huge 33-bit offset, so one compare covers both bounds.
  assign offset  = {1'b0, addr_reg} - {1'b0, BASE_ADDR};
  assign req_err = (offset >= SPAN) || bad_access(rwtype_reg, addr_reg[1:0]);
  assign idx     = offset[IDX_W+1:2];
  assign commit  = access_done && wen_reg && !req_err;

  dmem_lane_fmt u_lane_fmt (
    .word     (rd_word),
    .lane     (addr_reg[1:0]),
    .rwtype   (rwtype_reg),
    .sext     (sext_reg),
    .wdata    (wdata_reg),
    .rdata    (load_fmt),
    .be       (be),
    .wdata_sh (wdata_sh)
  );

  // One byte-wide array per lane so partial stores never need read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (commit && be[gi]) begin
        mem[idx] <= wdata_sh[gi*8 +: 8];
      end
    end

    assign rd_word[gi*8 +: 8] = mem[idx];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = ACCESS;
      ACCESS:  if (lat_cnt_reg == LAT_LAST) state_next = RESP;
      RESP:    if (resp_ready) state_next = req_valid ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= '0;
      wen_reg        <= 1'b0;
      sext_reg       <= 1'b0;
      rwtype_reg     <= RW_BYTE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        wen_reg     <= req_wen;
        sext_reg    <= req_sext;
        rwtype_reg  <= req_rwtype;
        addr_reg    <= req_addr;
        wdata_reg   <= req_wdata;
        lat_cnt_reg <= '0;
      end else if (state_reg == ACCESS) begin
        lat_cnt_reg <= lat_cnt_reg + 4'd1;
      end
      // Response registers only load on completion, so they hold under backpressure.
      if (access_done) begin
        resp_err_reg   <= req_err;
        resp_rdata_reg <= (req_err || wen_reg) ? '0 : load_fmt;
      end
    end
  end

  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule
